// File: rtl/m_mem_ctrl_pkg.sv
// Shared encodings for the M-stage data-memory controller: access sizes, FSM states, default bus timeout.
// Pure declarations; no latency or backpressure of its own.
package m_mem_ctrl_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/m_mem_ctrl_be_gen.sv
// Byte-enable, store-lane replication and alignment check for one access; purely combinational.
// Zero latency, no backpressure; size 11 is handled as a word.
module m_be_gen
    import m_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = (addr_lo != 2'b00);
        case (size)
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_rep  = {4{wdata[7:0]}};
                misaligned = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage load/store controller: one ready/ack bus transaction per aligned request, with timeout.
// Latency min 3 cycles (IDLE, BUS, DONE); stall held high from request acceptance until DONE.
module m_mem_ctrl
    import m_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic             misaligned;
    logic             start, ack_hit, to_hit;

    m_be_gen u_be_gen (
        .size       (req_size),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        start   = 1'b0;
        ack_hit = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !misaligned) begin
                    state_d = ST_BUS;
                    stall   = 1'b1;
                    start   = 1'b1;
                end
            end
            ST_BUS: begin
                stall = 1'b1;
                // An ack arriving on the final counted cycle still completes cleanly.
                if (bus_ack) begin
                    ack_hit = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    to_hit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= req_we;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= req_we ? be : 4'b1111;
                bus_wdata <= wdata_rep;
                cnt_q     <= '0;
                err_q     <= 1'b0;
            end
            if (state_q == ST_BUS) cnt_q <= cnt_q + CNT_W'(1);
            if (ack_hit) begin
                bus_req <= 1'b0;
                rdata   <= bus_rdata;
            end
            if (to_hit) begin
                bus_req <= 1'b0;
                rdata   <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign rdata_valid = (state_q == ST_DONE) && !bus_we && !err_q;
    assign exc_bus     = (state_q == ST_DONE) && err_q;
    assign exc_adel    = (state_q == ST_IDLE) && req_valid && misaligned && !req_we;
    assign exc_ades    = (state_q == ST_IDLE) && req_valid && misaligned && req_we;

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Bench for m_mem_ctrl: transaction-level expectations per cycle, compared on every falling edge.
module tb_m_mem_ctrl;
    import m_mem_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_we, bus_ack;
    logic [1:0]  req_size;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, rdata_valid, exc_adel, exc_ades, exc_bus, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    m_mem_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .exc_adel(exc_adel),
        .exc_ades(exc_ades), .exc_bus(exc_bus), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // expected outputs for the current cycle, written only by the stimulus thread
    logic        chk_en = 1'b0;
    logic        e_stall, e_rvalid, e_adel, e_ades, e_xbus, e_req, e_we;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_be;

    // literal expectations queued by stimulus, consumed by the compare process
    string       lit_nm [256];
    logic [31:0] lit_act[256];
    logic [31:0] lit_exp[256];
    int          lit_wr = 0;

    int acc_id = 0;

    // owned by the compare process
    int n_cmp = 0, n_bad = 0, lit_rd = 0, last_id = 0;
    int stall_seen = 0, rv_seen = 0, req_seen = 0, adel_seen = 0, ades_seen = 0, xbus_seen = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (acc_id != last_id) begin
            last_id = acc_id;
            stall_seen = 0; rv_seen = 0; req_seen = 0;
            adel_seen = 0; ades_seen = 0; xbus_seen = 0;
        end
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("rdata_valid", 32'(rdata_valid), 32'(e_rvalid));
            check("exc_adel", 32'(exc_adel), 32'(e_adel));
            check("exc_ades", 32'(exc_ades), 32'(e_ades));
            check("exc_bus", 32'(exc_bus), 32'(e_xbus));
            check("bus_req", 32'(bus_req), 32'(e_req));
            check("bus_we", 32'(bus_we), 32'(e_we));
            check("bus_addr", bus_addr, e_addr);
            check("bus_be", 32'(bus_be), 32'(e_be));
            check("bus_wdata", bus_wdata, e_wdata);
            check("rdata", rdata, e_rdata);
            stall_seen += int'(stall);
            rv_seen    += int'(rdata_valid);
            req_seen   += int'(bus_req);
            adel_seen  += int'(exc_adel);
            ades_seen  += int'(exc_ades);
            xbus_seen  += int'(exc_bus);
        end
        while (lit_rd < lit_wr) begin
            check(lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_nm[lit_wr]  = nm;
        lit_act[lit_wr] = act;
        lit_exp[lit_wr] = exp;
        lit_wr++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid = 1'b0;
        bus_ack   = 1'($urandom);
        bus_rdata = $urandom;
        e_stall = 1'b0; e_rvalid = 1'b0; e_xbus = 1'b0;
        e_req   = 1'b0; e_adel   = 1'b0; e_ades = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            req_we   = 1'($urandom);
            req_size = 2'($urandom);
            addr     = $urandom;
            cyc();
        end
        set_idle();
    endtask

    // One M-stage access; the slave acks on BUS cycle d (d > TO means never).
    task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int d, input logic [31:0] rd);
        logic        mis, err;
        logic [3:0]  be;
        logic [31:0] wr;
        int          n;
        case (sz)
            SZ_HALF: begin
                mis = a[0];
                be  = a[1] ? 4'hC : 4'h3;
                wr  = {16'h0, wd[15:0]} * 32'h0001_0001;
            end
            SZ_BYTE: begin
                mis = 1'b0;
                be  = 4'(1 << a[1:0]);
                wr  = {24'h0, wd[7:0]} * 32'h0101_0101;
            end
            default: begin
                mis = (a % 4) != 0;
                be  = 4'hF;
                wr  = wd;
            end
        endcase
        if (!we) be = 4'hF;
        acc_id++;
        req_valid = 1'b1; req_we = we; req_size = sz; addr = a; wdata = wd;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        e_stall = !mis; e_adel = mis && !we; e_ades = mis && we;
        e_req = 1'b0; e_rvalid = 1'b0; e_xbus = 1'b0;
        cyc();
        if (mis) begin
            set_idle();
            return;
        end
        err = d > TO;
        n   = err ? TO : d;
        e_addr = {a[31:2], 2'b00}; e_be = be; e_wdata = wr; e_we = we;
        e_adel = 1'b0; e_ades = 1'b0;
        for (int k = 1; k <= n; k++) begin
            bus_ack   = (k == d);
            bus_rdata = (k == d) ? rd : $urandom;
            e_stall = 1'b1; e_req = 1'b1;
            cyc();
        end
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        e_stall = 1'b0; e_req = 1'b0;
        e_rvalid = !we && !err; e_xbus = err;
        e_rdata  = err ? 32'h0 : rd;
        cyc();
        set_idle();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        post("rst_stall", 32'(stall), 0);
        post("rst_bus_req", 32'(bus_req), 0);
        post("rst_bus_addr", bus_addr, 0);
        post("rst_bus_be", 32'(bus_be), 0);
        post("rst_bus_wdata", bus_wdata, 0);
        post("rst_rdata", rdata, 0);
        post("rst_rdata_valid", 32'(rdata_valid), 0);
        cyc();
        e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0; e_rdata = '0;
        set_idle();
        chk_en = 1'b1;

        access(1'b1, SZ_WORD, 32'h1000, 32'hDEAD_BEEF, 2, 32'h0);
        post("sw_stall_cycles", stall_seen, 3);
        post("sw_rvalid_count", rv_seen, 0);
        post("sw_be", 32'(bus_be), 32'hF);
        post("sw_wdata", bus_wdata, 32'hDEAD_BEEF);

        access(1'b1, SZ_BYTE, 32'h1003, 32'h0000_00A5, 1, 32'h0);
        post("sb_be", 32'(bus_be), 32'h8);
        post("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        post("sb_addr", bus_addr, 32'h1000);

        access(1'b0, SZ_HALF, 32'h2002, 32'h0, 1, 32'h8001_7FFF);
        post("lh_stall_cycles", stall_seen, 2);
        post("lh_rvalid_count", rv_seen, 1);
        post("lh_rdata", rdata, 32'h8001_7FFF);

        access(1'b0, SZ_WORD, 32'h2001, 32'h0, 1, 32'h0);
        post("lw_mis_adel_count", adel_seen, 1);
        post("lw_mis_bus_req_count", req_seen, 0);
        post("lw_mis_stall_cycles", stall_seen, 0);

        access(1'b1, SZ_HALF, 32'h2003, 32'h1234, 1, 32'h0);
        post("sh_mis_ades_count", ades_seen, 1);

        access(1'b0, SZ_WORD, 32'h4000, 32'h0, 100, 32'h5555_5555);
        post("to_stall_cycles", stall_seen, TO + 1);
        post("to_exc_bus_count", xbus_seen, 1);
        post("to_rdata", rdata, 32'h0);

        access(1'b0, SZ_WORD, 32'h4004, 32'h0, TO, 32'h1234_5678);
        post("ack_last_exc_bus_count", xbus_seen, 0);
        post("ack_last_rvalid_count", rv_seen, 1);
        post("ack_last_rdata", rdata, 32'h1234_5678);

        for (int i = 0; i < 80; i++) begin
            access(1'($urandom), 2'($urandom), $urandom, $urandom,
                   $urandom_range(TO + 2, 1), $urandom);
            if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
        end

        // reset while a load is waiting on the bus, then a stray ack
        chk_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; addr = 32'h3000; bus_ack = 1'b0;
        repeat (3) cyc();
        reset = 1'b1; req_valid = 1'b0;
        cyc();
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_0000;
        #2;
        post("rst_bus_bus_req", 32'(bus_req), 0);
        post("rst_bus_stall", 32'(stall), 0);
        post("rst_bus_rvalid", 32'(rdata_valid), 0);
        cyc();
        bus_ack = 1'b0;
        #2;
        post("rst_bus_rdata_after_ack", rdata, 0);
        post("rst_bus_rvalid_after_ack", 32'(rdata_valid), 0);
        post("rst_bus_addr_after_ack", bus_addr, 0);
        cyc();
        e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0; e_rdata = '0;
        set_idle();
        chk_en = 1'b1;
        access(1'b0, SZ_BYTE, 32'h5001, 32'h0, 1, 32'hA1B2_C3D4);
        post("post_rst_rdata", rdata, 32'hA1B2_C3D4);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
